// File: rtl/micro_x86_fetch_if.sv
// Bus bundle between the fetch front end, instruction memory and decode.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and payload stable until then. imem_resp has no ready.
interface micro_x86_fetch_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/micro_x86_fetch.sv
// Sequential instruction fetch with a prefetch FIFO, in-flight request
// tracking and redirect flush that discards stale memory responses.
module micro_x86_fetch #(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  micro_x86_fetch_if.master      io_bus,
  output logic [$clog2(DEPTH):0] o_dbg_count,
  output logic [$clog2(DEPTH):0] o_dbg_inflight,
  output logic [$clog2(DEPTH):0] o_dbg_discard
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_discard;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];

  logic [CW:0] w_occ;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_resp_ok;
  logic        w_push;
  logic        w_pop;
  logic        w_instr_valid;

  // Requests are throttled so every outstanding response has a FIFO slot.
  assign w_occ         = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req_valid   = !reset && !io_bus.redirect_valid && (w_occ < (CW+1)'(DEPTH));
  assign w_req_fire    = w_req_valid && io_bus.imem_req_ready;
  assign w_resp_ok     = io_bus.imem_resp_valid && (r_inflight != '0);
  assign w_push        = !reset && w_resp_ok && (r_discard == '0) && !io_bus.redirect_valid;
  assign w_instr_valid = !reset && (r_count != '0) && !io_bus.redirect_valid;
  assign w_pop         = w_instr_valid && io_bus.instr_ready;

  assign io_bus.imem_req_valid = w_req_valid;
  assign io_bus.imem_req_addr  = reset ? RESET_PC : r_fetch_pc;
  assign io_bus.instr_valid    = w_instr_valid;
  assign io_bus.instr          = reset ? '0 : r_mem_instr[r_rd_ptr];
  assign io_bus.instr_pc       = reset ? '0 : r_mem_pc[r_rd_ptr];

  assign o_dbg_count    = r_count;
  assign o_dbg_inflight = r_inflight;
  assign o_dbg_discard  = r_discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (io_bus.redirect_valid) begin
      // Everything still outstanding belongs to the old stream.
      r_fetch_pc <= io_bus.redirect_pc;
      r_resp_pc  <= io_bus.redirect_pc;
      r_inflight <= r_inflight - CW'(w_resp_ok);
      r_discard  <= r_inflight - CW'(w_resp_ok);
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_resp_ok);
      if (w_resp_ok && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + ADDR_W'(4);
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
      r_mem_instr[r_wr_ptr] <= io_bus.imem_resp_data;
    end
  end
endmodule

// File: tb/tb_micro_x86_fetch.sv
// Bench for micro_x86_fetch: latency-modelled instruction memory, request
// address tracker and an in-order {pc, instr} scoreboard.
module tb_micro_x86_fetch;
  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  micro_x86_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();
  logic [2:0] dbg_count, dbg_inflight, dbg_discard;

  micro_x86_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_bus         (bus),
    .o_dbg_count    (dbg_count),
    .o_dbg_inflight (dbg_inflight),
    .o_dbg_discard  (dbg_discard)
  );

  // ---------------- models / scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [63:0] addr;
  } pend_t;

  typedef struct {
    int          cycles;
    int          lat;
    int          rdy_pct;
    int          req_pct;
    int          hold;
    logic [63:0] redir_pc;
    logic [63:0] exp_first_pc;
  } phase_t;

  pend_t       pend_q[$];
  logic [95:0] exp_q[$];
  logic [63:0] exp_req_addr;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int          lat = 1;
  logic        drv_req_ready = 1'b0;
  logic        drv_instr_ready = 1'b0;
  logic        drv_redirect = 1'b0;
  logic [63:0] drv_redirect_pc = 64'h0;

  int          req_cnt, pop_cnt, iv_cnt;
  logic        last_iv, last_rv, first_seen, wrap_seen;
  logic [63:0] last_addr, first_pc, prev_pop_pc, fifth_addr;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return 32'h1000_0000 + a[33:2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic        resp, hs_req, hs_instr;
    logic [63:0] raddr, a;
    logic [95:0] e;
    resp  = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    raddr = resp ? pend_q[0].addr : 64'h0;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_data(raddr) : 32'h0;
    bus.imem_req_ready  = drv_req_ready;
    bus.instr_ready     = drv_instr_ready;
    bus.redirect_valid  = drv_redirect;
    bus.redirect_pc     = drv_redirect_pc;
    #2;
    last_iv   = bus.instr_valid;
    last_rv   = bus.imem_req_valid;
    last_addr = bus.imem_req_addr;
    a         = bus.imem_req_addr;
    if (drv_redirect) begin
      chk("req_valid_during_redirect", {63'h0, bus.imem_req_valid}, 64'h0);
      chk("instr_valid_during_redirect", {63'h0, bus.instr_valid}, 64'h0);
    end
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req_addr);
    hs_req   = bus.imem_req_valid && drv_req_ready;
    hs_instr = bus.instr_valid && drv_instr_ready;
    if (bus.instr_valid) iv_cnt++;
    if (hs_instr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h with nothing expected", bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", bus.instr_pc, e[95:32]);
        chk("instr", {32'h0, bus.instr}, {32'h0, e[31:0]});
      end
      if (!first_seen) begin
        first_seen = 1'b1;
        first_pc   = bus.instr_pc;
      end
      if (prev_pop_pc == 64'hFFFF_FFFF_FFFF_FFFC && bus.instr_pc == 64'h0) wrap_seen = 1'b1;
      prev_pop_pc = bus.instr_pc;
      pop_cnt++;
    end
    @(posedge clk);
    if (resp) void'(pend_q.pop_front());
    if (hs_req) begin
      if (req_cnt == 4) fifth_addr = a;
      pend_q.push_back('{due: cyc + 32'(lat), addr: a});
      exp_q.push_back({a, mem_data(a)});
      exp_req_addr = a + 64'd4;
      req_cnt++;
    end
    if (drv_redirect) begin
      exp_q.delete();
      exp_req_addr = drv_redirect_pc;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 64'h0;
    drv_redirect = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_req_addr = RESET_PC;
    req_cnt = 0;
    pop_cnt = 0;
    iv_cnt = 0;
    first_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("reset_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
      chk("reset_instr_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("reset_instr_pc", bus.instr_pc, 64'h0);
      chk("reset_instr", {32'h0, bus.instr}, 64'h0);
      chk("reset_req_addr", bus.imem_req_addr, RESET_PC);
      chk("reset_count", {61'h0, dbg_count}, 64'h0);
      chk("reset_inflight", {61'h0, dbg_inflight}, 64'h0);
      chk("reset_discard", {61'h0, dbg_discard}, 64'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequences ----------------
  initial begin
    phase_t tbl[4];
    tbl[0] = '{cycles: 40, lat: 1, rdy_pct: 100, req_pct: 100, hold: 1, redir_pc: 64'h0000_0000_0000_2000, exp_first_pc: 64'h0000_0000_0000_2000};
    tbl[1] = '{cycles: 50, lat: 3, rdy_pct: 50,  req_pct: 70,  hold: 1, redir_pc: 64'h0000_0001_0000_0100, exp_first_pc: 64'h0000_0001_0000_0100};
    tbl[2] = '{cycles: 50, lat: 2, rdy_pct: 30,  req_pct: 100, hold: 3, redir_pc: 64'h0000_0000_00AB_CD00, exp_first_pc: 64'h0000_0000_00AB_CD00};
    tbl[3] = '{cycles: 60, lat: 4, rdy_pct: 80,  req_pct: 50,  hold: 2, redir_pc: 64'h8000_0000_0000_0040, exp_first_pc: 64'h8000_0000_0000_0040};

    // Startup with 1-cycle memory: 2-cycle fill, then one instr per cycle.
    do_reset(1);
    lat = 1;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b1;
    tick();
    chk("startup_first_req_valid", {63'h0, last_rv}, 64'h1);
    chk("startup_first_req_addr", last_addr, 64'h0);
    chk("startup_iv_c0", {63'h0, last_iv}, 64'h0);
    tick();
    chk("startup_iv_c1", {63'h0, last_iv}, 64'h0);
    tick();
    chk("startup_iv_c2", {63'h0, last_iv}, 64'h1);
    iv_cnt = 0;
    repeat (10) tick();
    chk("startup_throughput", 64'(iv_cnt), 64'd10);

    // Decode stalled: exactly DEPTH requests, then fetch stops.
    do_reset(0);
    lat = 1;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b0;
    repeat (10) tick();
    chk("stall_req_count", 64'(req_cnt), 64'd4);
    chk("stall_req_valid", {63'h0, last_rv}, 64'h0);
    chk("stall_fifo_count", {61'h0, dbg_count}, 64'd4);
    drv_instr_ready = 1'b1;
    repeat (8) tick();
    chk("stall_drained", 64'(pop_cnt >= 4), 64'h1);
    chk("stall_resume_addr", fifth_addr, 64'h10);

    // Memory not ready: address must hold at 0x8.
    do_reset(0);
    lat = 1;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b1;
    repeat (2) tick();
    drv_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req_valid", {63'h0, last_rv}, 64'h1);
      chk("hold_req_addr", last_addr, 64'h8);
    end
    drv_req_ready = 1'b1;
    tick();
    chk("hold_accept_addr", last_addr, 64'h8);
    tick();
    chk("hold_next_addr", last_addr, 64'hC);

    // Latency 3, redirect with two requests in flight.
    do_reset(0);
    lat = 3;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b1;
    repeat (2) tick();
    chk("redir_inflight_before", {61'h0, dbg_inflight}, 64'd2);
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h400;
    tick();
    drv_redirect = 1'b0;
    chk("redir_discard", {61'h0, dbg_discard}, 64'd2);
    first_seen = 1'b0;
    repeat (20) tick();
    chk("redir_first_seen", {63'h0, first_seen}, 64'h1);
    chk("redir_first_pc", first_pc, 64'h400);

    // Redirect coinciding with a response and instr_ready, count == 2.
    do_reset(0);
    lat = 2;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b0;
    repeat (4) tick();
    chk("coinc_count_before", {61'h0, dbg_count}, 64'd2);
    chk("coinc_inflight_before", {61'h0, dbg_inflight}, 64'd2);
    drv_instr_ready = 1'b1;
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h800;
    pop_cnt = 0;
    tick();
    drv_redirect = 1'b0;
    chk("coinc_no_pop", 64'(pop_cnt), 64'd0);
    chk("coinc_count_after", {61'h0, dbg_count}, 64'd0);
    chk("coinc_discard", {61'h0, dbg_discard}, 64'd1);
    chk("coinc_inflight_after", {61'h0, dbg_inflight}, 64'd1);
    first_seen = 1'b0;
    repeat (15) tick();
    chk("coinc_first_pc", first_pc, 64'h800);

    // Address wrap at the top of the address space.
    lat = 1;
    wrap_seen = 1'b0;
    prev_pop_pc = 64'h1;
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    drv_redirect = 1'b0;
    repeat (12) tick();
    chk("wrap_seen", {63'h0, wrap_seen}, 64'h1);

    // Table-driven random phases, each opened by a (possibly held) redirect.
    for (int p = 0; p < 4; p++) begin
      lat = tbl[p].lat;
      drv_req_ready = 1'b1;
      for (int h = 0; h < tbl[p].hold; h++) begin
        drv_redirect = 1'b1;
        drv_redirect_pc = (h == tbl[p].hold - 1) ? tbl[p].redir_pc : (tbl[p].redir_pc ^ 64'h1000);
        tick();
      end
      drv_redirect = 1'b0;
      first_seen = 1'b0;
      pop_cnt = 0;
      for (int c = 0; c < tbl[p].cycles; c++) begin
        drv_instr_ready = ($urandom_range(99) < 32'(tbl[p].rdy_pct));
        drv_req_ready   = ($urandom_range(99) < 32'(tbl[p].req_pct));
        tick();
      end
      chk("phase_first_seen", {63'h0, first_seen}, 64'h1);
      chk("phase_first_pc", first_pc, tbl[p].exp_first_pc);
    end

    // Mid-operation reset clears everything.
    drv_instr_ready = 1'b0;
    drv_req_ready = 1'b1;
    repeat (3) tick();
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
